// File: rtl/reorder_buffer_if.sv
// Entry type for the reorder buffer head slot, plus the dispatch/CDB/lookup/commit
// bundle that connects the buffer to the pipeline.
package reorder_buffer_pkg;

    // "type" is reserved in SystemVerilog, so the instruction-type field is entry_type.
    typedef struct packed {
        logic [1:0]  entry_type;
        logic        branch_pred;
        logic        branch_result;
        logic [31:0] destination;
        logic [31:0] value;
        logic [3:0]  ROB_number;
    } ROB_entry_t;

endpackage

interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic        alloc_en;
    logic [1:0]  alloc_type;
    logic [31:0] alloc_dest;
    logic        alloc_pred;
    logic [3:0]  alloc_rob;
    logic        rob_full;
    logic        rob_empty;

    logic        cdb_valid;
    logic [3:0]  cdb_rob;
    logic [31:0] cdb_value;
    logic        cdb_branch_result;

    logic [3:0]  qj_rob;
    logic [3:0]  qk_rob;
    logic        qj_ready;
    logic [31:0] qj_value;
    logic        qk_ready;
    logic [31:0] qk_value;

    ROB_entry_t  head;
    logic        rob_head_ready;
    logic        rd_en;
    logic        flush;

    modport master (
        output alloc_en, alloc_type, alloc_dest, alloc_pred,
        input  alloc_rob, rob_full, rob_empty,
        output cdb_valid, cdb_rob, cdb_value, cdb_branch_result,
        output qj_rob, qk_rob,
        input  qj_ready, qj_value, qk_ready, qk_value,
        input  head, rob_head_ready,
        output rd_en, flush
    );

    modport slave (
        input  alloc_en, alloc_type, alloc_dest, alloc_pred,
        output alloc_rob, rob_full, rob_empty,
        input  cdb_valid, cdb_rob, cdb_value, cdb_branch_result,
        input  qj_rob, qk_rob,
        output qj_ready, qj_value, qk_ready, qk_value,
        output head, rob_head_ready,
        input  rd_en, flush
    );

endinterface

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: in-order allocate at tail, out-of-order
// completion by tag from the CDB, in-order retire at head, flush on mispredict.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    reorder_buffer_if.slave    rob_if
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] ready_q, ready_d;
    logic [DEPTH-1:0] pred_q,  pred_d;
    logic [DEPTH-1:0] bres_q,  bres_d;
    logic [1:0]       type_q  [DEPTH];
    logic [1:0]       type_d  [DEPTH];
    logic [31:0]      dest_q  [DEPTH];
    logic [31:0]      dest_d  [DEPTH];
    logic [31:0]      value_q [DEPTH];
    logic [31:0]      value_d [DEPTH];

    logic [3:0]       head_ptr_q, head_ptr_d;
    logic [3:0]       tail_ptr_q, tail_ptr_d;
    logic [4:0]       count_q,    count_d;

    logic             full;
    logic             empty;
    logic             do_alloc;
    logic             do_deq;
    logic             do_cdb;

    assign full     = (count_q == 5'd16);
    assign empty    = (count_q == 5'd0);
    assign do_alloc = rob_if.alloc_en & ~full;
    assign do_deq   = rob_if.rd_en & ~empty;
    assign do_cdb   = rob_if.cdb_valid & valid_q[rob_if.cdb_rob];

    // Dequeue is applied after the CDB write so it wins on the same slot.
    always_comb begin
        valid_d    = valid_q;
        ready_d    = ready_q;
        pred_d     = pred_q;
        bres_d     = bres_q;
        type_d     = type_q;
        dest_d     = dest_q;
        value_d    = value_q;
        head_ptr_d = head_ptr_q;
        tail_ptr_d = tail_ptr_q;
        count_d    = count_q;

        if (rob_if.flush) begin
            valid_d    = '0;
            ready_d    = '0;
            head_ptr_d = '0;
            tail_ptr_d = '0;
            count_d    = '0;
        end else begin
            if (do_cdb) begin
                ready_d[rob_if.cdb_rob] = 1'b1;
                value_d[rob_if.cdb_rob] = rob_if.cdb_value;
                bres_d[rob_if.cdb_rob]  = rob_if.cdb_branch_result;
            end

            if (do_deq) begin
                valid_d[head_ptr_q] = 1'b0;
                ready_d[head_ptr_q] = 1'b0;
                head_ptr_d          = head_ptr_q + 4'd1;
            end

            if (do_alloc) begin
                valid_d[tail_ptr_q] = 1'b1;
                ready_d[tail_ptr_q] = 1'b0;
                type_d[tail_ptr_q]  = rob_if.alloc_type;
                dest_d[tail_ptr_q]  = rob_if.alloc_dest;
                pred_d[tail_ptr_q]  = rob_if.alloc_pred;
                value_d[tail_ptr_q] = '0;
                bres_d[tail_ptr_q]  = 1'b0;
                tail_ptr_d          = tail_ptr_q + 4'd1;
            end

            case ({do_alloc, do_deq})
                2'b10:   count_d = count_q + 5'd1;
                2'b01:   count_d = count_q - 5'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= '0;
            ready_q    <= '0;
            pred_q     <= '0;
            bres_q     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                type_q[i]  <= '0;
                dest_q[i]  <= '0;
                value_q[i] <= '0;
            end
            head_ptr_q <= '0;
            tail_ptr_q <= '0;
            count_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            ready_q    <= ready_d;
            pred_q     <= pred_d;
            bres_q     <= bres_d;
            type_q     <= type_d;
            dest_q     <= dest_d;
            value_q    <= value_d;
            head_ptr_q <= head_ptr_d;
            tail_ptr_q <= tail_ptr_d;
            count_q    <= count_d;
        end
    end

    assign rob_if.alloc_rob = tail_ptr_q;
    assign rob_if.rob_full  = full;
    assign rob_if.rob_empty = empty;

    // Operand lookup: a same-cycle CDB hit on a valid slot bypasses the stored value.
    always_comb begin
        rob_if.qj_ready = 1'b0;
        rob_if.qj_value = '0;
        if (valid_q[rob_if.qj_rob]) begin
            if (rob_if.cdb_valid && (rob_if.cdb_rob == rob_if.qj_rob)) begin
                rob_if.qj_ready = 1'b1;
                rob_if.qj_value = rob_if.cdb_value;
            end else begin
                rob_if.qj_ready = ready_q[rob_if.qj_rob];
                rob_if.qj_value = value_q[rob_if.qj_rob];
            end
        end
    end

    always_comb begin
        rob_if.qk_ready = 1'b0;
        rob_if.qk_value = '0;
        if (valid_q[rob_if.qk_rob]) begin
            if (rob_if.cdb_valid && (rob_if.cdb_rob == rob_if.qk_rob)) begin
                rob_if.qk_ready = 1'b1;
                rob_if.qk_value = rob_if.cdb_value;
            end else begin
                rob_if.qk_ready = ready_q[rob_if.qk_rob];
                rob_if.qk_value = value_q[rob_if.qk_rob];
            end
        end
    end

    always_comb begin
        rob_if.head.entry_type    = type_q[head_ptr_q];
        rob_if.head.branch_pred   = pred_q[head_ptr_q];
        rob_if.head.branch_result = bres_q[head_ptr_q];
        rob_if.head.destination   = dest_q[head_ptr_q];
        rob_if.head.value         = value_q[head_ptr_q];
        rob_if.head.ROB_number    = head_ptr_q;
        rob_if.rob_head_ready     = valid_q[head_ptr_q] & ready_q[head_ptr_q];
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: scoreboard of allocated entries
// popped and compared against the head at each retire.
module tb_reorder_buffer;

    logic clk;
    logic rst_n;

    reorder_buffer_if rob_if ();

    reorder_buffer #(.DEPTH(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rob_if (rob_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] dest;
        logic [1:0]  typ;
    } sb_t;

    sb_t         sb [$];
    logic [31:0] mval [16];
    logic [3:0]  mtail;
    int          n_cmp;
    int          n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mtail = '0;
        sb.delete();
    endtask

    task automatic alloc(input logic [1:0] t, input logic [31:0] d, input logic p);
        sb_t e;
        rob_if.alloc_en   = 1'b1;
        rob_if.alloc_type = t;
        rob_if.alloc_dest = d;
        rob_if.alloc_pred = p;
        #1;
        chk("alloc_rob", {28'd0, rob_if.alloc_rob}, {28'd0, mtail});
        e.tag  = mtail;
        e.dest = d;
        e.typ  = t;
        sb.push_back(e);
        mval[mtail] = '0;
        tick();
        rob_if.alloc_en = 1'b0;
        mtail = mtail + 4'd1;
    endtask

    task automatic cdb(input logic [3:0] t, input logic [31:0] v);
        rob_if.cdb_valid         = 1'b1;
        rob_if.cdb_rob           = t;
        rob_if.cdb_value         = v;
        rob_if.cdb_branch_result = 1'b0;
        mval[t] = v;
        tick();
        rob_if.cdb_valid = 1'b0;
    endtask

    // Compares the current head against the oldest scoreboard entry and pops it.
    task automatic head_check();
        sb_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL sb_underflow: observed 0 entries expected at least 1");
        end else begin
            e = sb.pop_front();
            chk("head_ready", {31'd0, rob_if.rob_head_ready}, 32'd1);
            chk("head_tag",   {28'd0, rob_if.head.ROB_number}, {28'd0, e.tag});
            chk("head_dest",  rob_if.head.destination, e.dest);
            chk("head_type",  {30'd0, rob_if.head.entry_type}, {30'd0, e.typ});
            chk("head_value", rob_if.head.value, mval[e.tag]);
        end
    endtask

    task automatic retire();
        head_check();
        rob_if.rd_en = 1'b1;
        tick();
        rob_if.rd_en = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        mtail = '0;
        rob_if.alloc_en = 0;  rob_if.alloc_type = '0; rob_if.alloc_dest = '0; rob_if.alloc_pred = 0;
        rob_if.cdb_valid = 0; rob_if.cdb_rob = '0; rob_if.cdb_value = '0; rob_if.cdb_branch_result = 0;
        rob_if.qj_rob = '0;   rob_if.qk_rob = '0;  rob_if.rd_en = 0;    rob_if.flush = 0;
        for (int i = 0; i < 16; i++) mval[i] = '0;

        // Reset then idle
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_empty", {31'd0, rob_if.rob_empty}, 32'd1);
        chk("rst_full", {31'd0, rob_if.rob_full}, 32'd0);
        chk("rst_alloc_rob", {28'd0, rob_if.alloc_rob}, 32'd0);
        chk("rst_head_ready", {31'd0, rob_if.rob_head_ready}, 32'd0);
        chk("rst_head_dest", rob_if.head.destination, 32'd0);
        chk("rst_head_value", rob_if.head.value, 32'd0);
        chk("rst_head_misc", {24'd0, rob_if.head.entry_type, rob_if.head.branch_pred,
                              rob_if.head.branch_result, rob_if.head.ROB_number}, 32'd0);
        chk("rst_qj", {rob_if.qj_ready, rob_if.qj_value[30:0]}, 32'd0);
        chk("rst_qk", {rob_if.qk_ready, rob_if.qk_value[30:0]}, 32'd0);

        // Fill and wrap
        for (int i = 0; i < 16; i++) alloc(2'b10, 32'(i + 1), 1'b0);
        chk("fill_full", {31'd0, rob_if.rob_full}, 32'd1);
        chk("fill_empty", {31'd0, rob_if.rob_empty}, 32'd0);
        rob_if.alloc_en = 1'b1;
        rob_if.alloc_dest = 32'hFFFF;
        tick();
        rob_if.alloc_en = 1'b0;
        chk("ovf_full", {31'd0, rob_if.rob_full}, 32'd1);
        chk("ovf_alloc_rob", {28'd0, rob_if.alloc_rob}, 32'd0);
        chk("ovf_head_dest", rob_if.head.destination, 32'd1);
        cdb(4'd0, 32'h100);
        cdb(4'd1, 32'h101);
        retire();
        retire();
        chk("two_out_full", {31'd0, rob_if.rob_full}, 32'd0);
        alloc(2'b10, 32'd17, 1'b0);
        alloc(2'b10, 32'd18, 1'b0);
        chk("refill_full", {31'd0, rob_if.rob_full}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            logic [3:0] t;
            t = 4'(i + 2);
            cdb(t, 32'h1000 + 32'(i));
        end
        for (int i = 0; i < 16; i++) retire();
        chk("drain_empty", {31'd0, rob_if.rob_empty}, 32'd1);
        chk("drain_head_ready", {31'd0, rob_if.rob_head_ready}, 32'd0);

        // Out-of-order completion
        do_reset();
        #1;
        chk("rst2_alloc_rob", {28'd0, rob_if.alloc_rob}, 32'd0);
        alloc(2'b10, 32'd5, 1'b0);
        alloc(2'b10, 32'd6, 1'b0);
        alloc(2'b10, 32'd7, 1'b0);
        cdb(4'd2, 32'hDEAD);
        cdb(4'd1, 32'hBEEF);
        chk("ooo_not_ready", {31'd0, rob_if.rob_head_ready}, 32'd0);
        cdb(4'd0, 32'h1);
        chk("ooo_head_val", rob_if.head.value, 32'h1);
        retire();
        retire();
        retire();
        chk("ooo_empty", {31'd0, rob_if.rob_empty}, 32'd1);

        // Store hold: head stays presented while commit waits on memory
        alloc(2'b01, 32'h8000_0040, 1'b0);
        cdb(4'd3, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_ready", {31'd0, rob_if.rob_head_ready}, 32'd1);
            chk("hold_tag", {28'd0, rob_if.head.ROB_number}, 32'd3);
            chk("hold_type", {30'd0, rob_if.head.entry_type}, 32'd1);
        end
        retire();
        chk("hold_empty", {31'd0, rob_if.rob_empty}, 32'd1);

        // Bypass and simultaneous events
        do_reset();
        for (int i = 0; i < 5; i++) alloc(2'b10, 32'(10 + i), 1'b0);
        rob_if.qj_rob    = 4'd3;
        rob_if.qk_rob    = 4'd2;
        rob_if.cdb_valid = 1'b1;
        rob_if.cdb_rob   = 4'd3;
        rob_if.cdb_value = 32'h55;
        mval[3] = 32'h55;
        #1;
        chk("byp_qj_ready", {31'd0, rob_if.qj_ready}, 32'd1);
        chk("byp_qj_value", rob_if.qj_value, 32'h55);
        chk("byp_qk_ready", {31'd0, rob_if.qk_ready}, 32'd0);
        chk("byp_qk_value", rob_if.qk_value, 32'd0);
        tick();
        rob_if.cdb_valid = 1'b0;
        #1;
        chk("stored_qj_ready", {31'd0, rob_if.qj_ready}, 32'd1);
        chk("stored_qj_value", rob_if.qj_value, 32'h55);
        rob_if.qk_rob    = 4'd9;
        rob_if.cdb_valid = 1'b1;
        rob_if.cdb_rob   = 4'd9;
        rob_if.cdb_value = 32'h99;
        #1;
        chk("byp_invalid_ready", {31'd0, rob_if.qk_ready}, 32'd0);
        chk("byp_invalid_value", rob_if.qk_value, 32'd0);
        tick();
        rob_if.cdb_valid = 1'b0;
        cdb(4'd0, 32'h77);
        // alloc + dequeue at count 5
        head_check();
        rob_if.rd_en = 1'b1;
        alloc(2'b10, 32'd15, 1'b0);
        rob_if.rd_en = 1'b0;
        for (int i = 0; i < 10; i++) alloc(2'b11, 32'(20 + i), 1'b0);
        chk("cnt15_full", {31'd0, rob_if.rob_full}, 32'd0);
        alloc(2'b11, 32'd30, 1'b0);
        chk("cnt16_full", {31'd0, rob_if.rob_full}, 32'd1);
        // alloc + dequeue at count 16: allocation rejected, dequeue proceeds
        cdb(4'd1, 32'h11);
        head_check();
        rob_if.rd_en    = 1'b1;
        rob_if.alloc_en = 1'b1;
        tick();
        rob_if.rd_en    = 1'b0;
        rob_if.alloc_en = 1'b0;
        chk("full_deq_full", {31'd0, rob_if.rob_full}, 32'd0);
        chk("full_deq_tail", {28'd0, rob_if.alloc_rob}, 32'd1);
        chk("full_deq_head", {28'd0, rob_if.head.ROB_number}, 32'd2);

        // Flush with a branch at head
        do_reset();
        alloc(2'b00, 32'h400, 1'b1);
        for (int i = 0; i < 6; i++) alloc(2'b10, 32'(40 + i), 1'b0);
        chk("br_head_type", {30'd0, rob_if.head.entry_type}, 32'd0);
        chk("br_head_pred", {31'd0, rob_if.head.branch_pred}, 32'd1);
        chk("br_alloc_rob", {28'd0, rob_if.alloc_rob}, 32'd7);
        rob_if.flush     = 1'b1;
        rob_if.alloc_en  = 1'b1;
        rob_if.cdb_valid = 1'b1;
        rob_if.cdb_rob   = 4'd0;
        rob_if.cdb_value = 32'h123;
        tick();
        rob_if.flush     = 1'b0;
        rob_if.alloc_en  = 1'b0;
        rob_if.cdb_valid = 1'b0;
        sb.delete();
        mtail = '0;
        chk("flush_empty", {31'd0, rob_if.rob_empty}, 32'd1);
        chk("flush_alloc_rob", {28'd0, rob_if.alloc_rob}, 32'd0);
        chk("flush_head_ready", {31'd0, rob_if.rob_head_ready}, 32'd0);
        rob_if.qj_rob    = 4'd4;
        rob_if.cdb_valid = 1'b1;
        rob_if.cdb_rob   = 4'd4;
        rob_if.cdb_value = 32'h44;
        #1;
        chk("postflush_byp", {31'd0, rob_if.qj_ready}, 32'd0);
        tick();
        rob_if.cdb_valid = 1'b0;
        #1;
        chk("postflush_qj_ready", {31'd0, rob_if.qj_ready}, 32'd0);
        chk("postflush_qj_value", rob_if.qj_value, 32'd0);
        chk("postflush_empty", {31'd0, rob_if.rob_empty}, 32'd1);
        // alloc + dequeue at count 0: dequeue ignored
        rob_if.rd_en = 1'b1;
        alloc(2'b10, 32'd50, 1'b0);
        rob_if.rd_en = 1'b0;
        chk("empty_deq_empty", {31'd0, rob_if.rob_empty}, 32'd0);
        chk("empty_deq_tail", {28'd0, rob_if.alloc_rob}, 32'd1);
        chk("empty_deq_head_dest", rob_if.head.destination, 32'd50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
